// File: rtl/cc_cond_unit.sv
// cc_cond_unit: Y86-64 condition-code register, Cnd evaluator and E-to-M pipeline register.
// Define UNSIGNED_COND_EN to add the CF-based unsigned conditions (ifun 7-10).
module cc_cond_unit #(
    parameter int         BIT_WID = 64,
    parameter logic [3:0] RNONE   = 4'hF,
    parameter logic [3:0] INOP    = 4'h1,
    parameter logic [3:0] IRRMOVQ = 4'h2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         CCin,
    input  logic               setCC,
    input  logic [3:0]         E_icode,
    input  logic [3:0]         E_ifun,
    input  logic [BIT_WID-1:0] E_valE,
    input  logic [3:0]         E_dstE,
    input  logic               stall,
    input  logic               bubble,
    output logic [3:0]         CC,
    output logic               Cnd,
    output logic               badCond,
    output logic [3:0]         M_icode,
    output logic               M_Cnd,
    output logic [BIT_WID-1:0] M_valE,
    output logic [3:0]         M_dstE
);
    logic zf, sf, of, lt;
    assign zf = CC[0];
    assign sf = CC[1];
    assign of = CC[2];
    assign lt = sf ^ of;
`ifdef UNSIGNED_COND_EN
    logic cf;
    assign cf = CC[3];
`endif
    // Cnd always reads the stored flags, so a same-cycle setCC is not visible yet
    always_comb begin
        Cnd     = 1'b0;
        badCond = 1'b0;
        case (E_ifun)
            4'd0:    Cnd = 1'b1;
            4'd1:    Cnd = lt | zf;
            4'd2:    Cnd = lt;
            4'd3:    Cnd = zf;
            4'd4:    Cnd = !zf;
            4'd5:    Cnd = !lt;
            4'd6:    Cnd = !lt & !zf;
`ifdef UNSIGNED_COND_EN
            4'd7:    Cnd = cf;
            4'd8:    Cnd = !cf;
            4'd9:    Cnd = !cf & !zf;
            4'd10:   Cnd = cf | zf;
`endif
            default: badCond = 1'b1;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst)
            CC <= 4'b0001;
        else if (setCC && !stall)
            CC <= CCin;
    end
    always_ff @(posedge clk) begin
        if (rst || (!stall && bubble)) begin
            M_icode <= INOP;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_dstE  <= RNONE;
        end else if (!stall) begin
            M_icode <= E_icode;
            M_Cnd   <= Cnd;
            M_valE  <= E_valE;
            M_dstE  <= (E_icode == IRRMOVQ && !Cnd) ? RNONE : E_dstE;
        end
    end
endmodule

// File: doc/cc_cond_unit.md
# cc_cond_unit

Condition-code register, branch/move condition evaluator and execute-to-memory pipeline register for the Y86-64 core. It sits directly downstream of the ALU and holds the ALU's `CC` flags across instructions. It resolves the `Cnd` signal for `jXX`/`cmovXX` from the stored flags. It latches `valE`, the destination register and the condition result into the M stage, with stall and bubble control from pipeline control.

## Interface
Parameters:
- `BIT_WID`, 64, datapath width of `valE`
- `RNONE`, 4'hF, register ID meaning "no destination"
- `INOP`, 4'h1, icode inserted on bubble/reset
- `IRRMOVQ`, 4'h2, icode of `rrmovq`/`cmovXX`

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `CCin`  in  4  ALU flags, index `ZF`=0, `SF`=1, `OF`=2, `CF`=3
- `setCC`  in  1  load `CCin` into CC register this cycle
- `E_icode`  in  4  execute-stage icode
- `E_ifun`  in  4  execute-stage ifun (condition selector)
- `E_valE`  in  BIT_WID  ALU result `valE`
- `E_dstE`  in  4  execute-stage destination register
- `stall`  in  1  hold M register and CC register
- `bubble`  in  1  load NOP into M register
- `CC`  out  4  stored condition codes
- `Cnd`  out  1  combinational condition result for current E instruction
- `badCond`  out  1  combinational; `E_ifun` is not a defined condition
- `M_icode`  out  4  registered icode
- `M_Cnd`  out  1  registered `Cnd`
- `M_valE`  out  BIT_WID  registered `valE`
- `M_dstE`  out  4  registered, post-cmov-squash destination

## Operation
- CC register: loads `CCin` when `setCC && !stall && !rst`; otherwise holds.
- `Cnd` is evaluated from the stored `CC` (pre-update value), never from `CCin`.
- Condition codes by `E_ifun`:
  - 0 always → 1
  - 1 le → (SF^OF)|ZF
  - 2 l → SF^OF
  - 3 e → ZF
  - 4 ne → !ZF
  - 5 ge → !(SF^OF)
  - 6 g → !(SF^OF)&!ZF
- Undefined `E_ifun` gives `Cnd`=0 and `badCond`=1; for defined codes `badCond`=0. `badCond` is informational only and does not change the M register.
- Destination squash: when `E_icode==IRRMOVQ && !Cnd`, the next `M_dstE` is `RNONE`; otherwise it is `E_dstE`.
- M register priority, highest first:
  1. `rst`: load reset values.
  2. `stall`: hold all fields.
  3. `bubble`: load NOP values.
  4. Otherwise: load E values.
- NOP/reset values: `M_icode`=`INOP`, `M_Cnd`=0, `M_valE`=0, `M_dstE`=`RNONE`.
- `stall` && `bubble` together: stall wins; the register holds, and CC also holds.

## Timing
- Reset values: `CC`=4'b0001 (ZF set), `M_icode`=4'h1, `M_Cnd`=0, `M_valE`=0, `M_dstE`=4'hF.
- `Cnd`/`badCond`: zero-cycle combinational from `CC` and `E_ifun`.
- M outputs: 1-cycle latency from E inputs.
- CC written at edge N is visible to `Cnd` in cycle N+1.
  - A flag-setting `opq` immediately followed by `jXX` therefore sees the new flags.
  - An instruction in the same cycle as `setCC` sees the old flags.
- `rst` asserted mid-operation clears both CC and M at the next edge, regardless of `stall`/`bubble`/`setCC`.
- No internal wrap-around or counters; widths are fixed, and `valE` passes through unmodified.

## Configuration
- `UNSIGNED_COND_EN` defined: adds unsigned conditions using `CF`, with `badCond` asserted only for ifun 11–15.
  - 7 b → CF
  - 8 ae → !CF
  - 9 a → !CF&!ZF
  - 10 be → CF|ZF
- Not defined: ifun 7–15 are undefined (`Cnd`=0, `badCond`=1), and `CC[CF]` is still stored but unused by evaluation.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with random inputs → `CC`=4'b0001, `M_icode`=1, `M_dstE`=F, `M_valE`=0, `M_Cnd`=0.
- Flag load then branch:
  - Cycle 0: `setCC`=1, `CCin`=4'b0010 (SF), `E_ifun`=2 → `Cnd`=0 (old ZF-only flags).
  - Cycle 1: `E_ifun`=2 → `Cnd`=1; `E_ifun`=4 → `Cnd`=1; `E_ifun`=6 → `Cnd`=0.
- cmov squash:
  - `CC`=ZF, `E_icode`=2, `E_ifun`=4, `E_dstE`=3, `E_valE`=0x55 → next `M_dstE`=F, `M_valE`=0x55, `M_Cnd`=0.
  - Same with `E_ifun`=3 → `M_dstE`=3.
- Stall/bubble:
  - Load `E_valE`=0x1234, then `stall`=1 for 3 cycles with changing inputs and `setCC`=1 → `M_valE` stays 0x1234, `CC` unchanged.
  - `stall`=`bubble`=1 → still holds.
  - `bubble` only → NOP values.
- Undefined ifun: `E_ifun`=7 → `Cnd`=0, `badCond`=1 without the macro. With `UNSIGNED_COND_EN` and `CC`=4'b1000 → `Cnd`=1, `badCond`=0; `E_ifun`=12 → `badCond`=1.
- Reset mid-stream: `rst`=1 during `stall`=1 with `setCC`=1 → next cycle shows full reset values.
